// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the core memory port arbiter: FSM state
//               encoding, owner IDs and the default address/data widths that
//               the fetch and execute stages also use.
// Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Default bus widths for the 1 MB core memory.
  localparam int unsigned c_ADDR_W = 20;
  localparam int unsigned c_DATA_W = 32;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Transaction owner IDs.
  localparam logic c_OWN_IF = 1'b0;
  localparam logic c_OWN_D  = 1'b1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Winner select for the memory port arbiter plus the fetch
//               starvation streak counter. Data wins a collision unless data
//               has already won STARVE_MAX times in a row while fetch waited.
// Ports       : clk, rst_n  - clock, async active-low reset
//               i_if_req    - fetch request
//               i_d_req     - data request
//               i_take      - a grant is issued this cycle (updates streak)
//               o_pick_d    - 1 = data wins, 0 = fetch wins
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_take,
  output logic o_pick_d
);

  localparam logic [3:0] c_STARVE = 4'(STARVE_MAX);

  logic [3:0] r_streak;
  logic       w_pick_d;

  // Fetch alone, or fetch colliding with a saturated streak, wins.
  always_comb begin
    w_pick_d = i_d_req && (!i_if_req || (r_streak != c_STARVE));
  end

  assign o_pick_d = w_pick_d;

  // Streak only counts data grants that actually made fetch wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= 4'd0;
    end else if (i_take) begin
      if (w_pick_d && i_if_req) begin
        if (r_streak != c_STARVE) begin
          r_streak <= r_streak + 4'd1;
        end
      end else begin
        r_streak <= 4'd0;
      end
    end
  end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises fetch (read-only) and execute data (load/store)
//               accesses onto the single-ported core memory, one outstanding
//               transaction at a time, with data priority, bounded fetch
//               starvation and a response timeout.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               if_req/if_addr                  - fetch request
//               if_gnt/if_rvalid/if_rdata       - fetch grant and response
//               d_req/d_we/d_addr/d_wdata       - data request
//               d_gnt/d_rvalid/d_rdata          - data grant and response
//               m_req/m_we/m_addr/m_wdata       - memory request
//               m_ready/m_rvalid/m_rdata        - memory handshake/response
//               err                             - timeout abort pulse
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = c_ADDR_W,
  parameter int unsigned DATA_W      = c_DATA_W,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  // Timeout fires on the WAIT cycle whose count is the last one allowed.
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_we;
  logic [7:0]        r_tmo;

  logic              w_take;
  logic              w_pick_d;
  logic              w_tmo_hit;
  logic              w_done;
  logic [DATA_W-1:0] w_resp_data;

  assign w_take    = (r_state == IDLE) && (if_req || d_req);
  assign w_tmo_hit = (r_state == WAIT) && !m_rvalid && (r_tmo == c_TMO_LAST);
  assign w_done    = (r_state == WAIT) && (m_rvalid || w_tmo_hit);
  // Stores and aborted transactions return zero data.
  assign w_resp_data = (m_rvalid && !r_we) ? m_rdata : '0;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .i_take   (w_take),
    .o_pick_d (w_pick_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= c_OWN_IF;
      r_we      <= 1'b0;
      r_tmo     <= 8'd0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      err       <= 1'b0;
    end else begin
      // Grant, response and error outputs are single-cycle pulses.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      err       <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state <= ISSUE;
            m_req   <= 1'b1;
            if (w_pick_d) begin
              r_owner <= c_OWN_D;
              r_we    <= d_we;
              d_gnt   <= 1'b1;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              r_owner <= c_OWN_IF;
              r_we    <= 1'b0;
              if_gnt  <= 1'b1;
              m_we    <= 1'b0;
              m_addr  <= if_addr;
              m_wdata <= '0;
            end
          end
        end

        ISSUE: begin
          if (m_ready) begin
            r_state <= WAIT;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            r_tmo   <= 8'd0;
          end
        end

        WAIT: begin
          if (w_done) begin
            r_state <= IDLE;
            err     <= w_tmo_hit;
            if (r_owner == c_OWN_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= w_resp_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= w_resp_data;
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Table of single
//               transactions plus directed collision, timeout and reset
//               sequences; responses are checked against a scoreboard queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [19:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [19:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [19:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        err;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        owner;   // 1 = data, 0 = fetch
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          rdy;     // cycles of m_ready=0 before acceptance
    int          rsp;     // cycles in WAIT before m_rvalid
    logic [31:0] word;    // memory response word
    logic [31:0] exp;     // expected owner rdata
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_rv  = 0;
  int   last_err = 0;

  // Memory model controls.
  int          rdy_dly   = 0;
  int          rsp_dly   = 0;
  logic        mute      = 1'b0;
  int          late_dly  = 0;
  logic        use_fn    = 1'b0;
  logic [31:0] resp_word = 32'h0;

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {12'hB0B, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {25'b0, if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, err}, 32'h0);
    chk({tag, "_maddr"}, {12'b0, m_addr}, 32'h0);
    chk({tag, "_mwdata"}, m_wdata, 32'h0);
    chk({tag, "_ifrdata"}, if_rdata, 32'h0);
    chk({tag, "_drdata"}, d_rdata, 32'h0);
    chk({tag, "_state"}, 32'(dut.r_state), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory responder: accepts after rdy_dly cycles, answers after rsp_dly
  // WAIT cycles, or stays silent (optionally answering late) when muted.
  initial begin
    logic [19:0] a;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        a = m_addr;
        repeat (rdy_dly) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        if (!mute) begin
          repeat (rsp_dly) @(negedge clk);
          m_rvalid = 1'b1;
          m_rdata  = use_fn ? mem_word(a) : resp_word;
          @(negedge clk);
          m_rvalid = 1'b0;
        end else if (late_dly > 0) begin
          repeat (late_dly) @(negedge clk);
          m_rvalid = 1'b1;
          m_rdata  = 32'hBADBAD00;
          @(negedge clk);
          m_rvalid = 1'b0;
        end
      end
    end
  end

  // Response monitor: every owner rvalid must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (if_rvalid || d_rvalid) begin
          last_rv = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
          end else begin
            e = sb.pop_front();
            chk("rv_owner", {30'b0, if_rvalid, d_rvalid}, e.owner ? 32'd1 : 32'd2);
            chk("rv_rdata", e.owner ? d_rdata : if_rdata, e.data);
            chk("rv_err", {31'b0, err}, {31'b0, e.err});
          end
        end else if (err) begin
          chk("err_without_rvalid", {31'b0, err}, 32'h0);
        end
        if (err) last_err = cyc;
      end
    end
  end

  task automatic wait_gnt(output int g, output logic ok);
    ok = 1'b0;
    g  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        ok = 1'b1;
        g  = cyc;
        break;
      end
    end
    chk("gnt_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_sb(input string nm, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int   start, g;
    logic ok;
    logic [31:0] wd;
    rdy_dly   = v.rdy;
    rsp_dly   = v.rsp;
    mute      = 1'b0;
    late_dly  = 0;
    use_fn    = 1'b0;
    resp_word = v.word;
    wd        = v.is_if ? 32'h0 : v.wdata;
    sb.push_back('{owner: !v.is_if, data: v.exp, err: 1'b0});
    @(posedge clk);
    #1;
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    start = cyc;
    wait_gnt(g, ok);
    chk("gnt_lat", g - start, 32'd1);
    chk("gnt_who", {30'b0, if_gnt, d_gnt}, v.is_if ? 32'd2 : 32'd1);
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int k = 0; k <= v.rdy; k++) begin
      if (k > 0) @(negedge clk);
      chk("m_req", {31'b0, m_req}, 32'd1);
      chk("m_we", {31'b0, m_we}, {31'b0, v.we & !v.is_if});
      chk("m_addr", {12'b0, m_addr}, {12'b0, v.addr});
      chk("m_wdata", m_wdata, wd);
    end
    wait_sb("rv_seen", 50);
    chk("rv_lat", last_rv - g, 32'(2 + v.rdy + v.rsp));
  endtask

  vec_t tbl[6];

  initial begin
    int   g;
    int   ng;
    int   n;
    logic ok;

    tbl[0] = '{is_if:1'b0, we:1'b0, addr:20'h00100, wdata:32'h0,        rdy:0, rsp:0, word:32'hCAFE0001, exp:32'hCAFE0001};
    tbl[1] = '{is_if:1'b0, we:1'b1, addr:20'hFFFFC, wdata:32'h12345678, rdy:3, rsp:1, word:32'hDEADBEEF, exp:32'h0};
    tbl[2] = '{is_if:1'b0, we:1'b0, addr:20'h0ABCD, wdata:32'h0,        rdy:1, rsp:4, word:32'h5A5A1234, exp:32'h5A5A1234};
    tbl[3] = '{is_if:1'b1, we:1'b0, addr:20'hFFFFF, wdata:32'h0,        rdy:2, rsp:2, word:32'h0000FFFF, exp:32'h0000FFFF};
    tbl[4] = '{is_if:1'b0, we:1'b1, addr:20'h00000, wdata:32'hFFFFFFFF, rdy:0, rsp:0, word:32'h11111111, exp:32'h0};
    tbl[5] = '{is_if:1'b1, we:1'b0, addr:20'h00040, wdata:32'h0,        rdy:0, rsp:0, word:32'hE3A00001, exp:32'hE3A00001};

    rst_n   = 1'b0;
    if_req  = 1'b0; if_addr = 20'h0;
    d_req   = 1'b0; d_we = 1'b0; d_addr = 20'h0; d_wdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single transactions from the table.
    foreach (tbl[i]) run_vec(tbl[i]);
    chk("streak_after_fetch", {28'b0, dut.u_pick.r_streak}, 32'd0);

    // Both requesters held: four data grants, then fetch, repeating.
    rdy_dly = 0; rsp_dly = 0; mute = 1'b0; use_fn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) sb.push_back('{owner: 1'b0, data: mem_word(20'h01230), err: 1'b0});
      else            sb.push_back('{owner: 1'b1, data: mem_word(20'h04560), err: 1'b0});
    end
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 20'h01230;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 20'h04560; d_wdata = 32'h0;
    ng = 0;
    n  = 0;
    while (ng < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_gnt || d_gnt) begin
        chk("grant_order", {30'b0, if_gnt, d_gnt}, (ng % 5 == 4) ? 32'd2 : 32'd1);
        ng++;
        if (ng == 10) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("grant_count", ng, 32'd10);
    wait_sb("collide_drain", 50);

    // Timeout: accepted but never answered; a late answer must be dropped.
    use_fn = 1'b0; mute = 1'b1; late_dly = 300; rdy_dly = 0;
    sb.push_back('{owner: 1'b1, data: 32'h0, err: 1'b1});
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h02468;
    wait_gnt(g, ok);
    d_req = 1'b0;
    wait_sb("tmo_seen", 300);
    chk("tmo_lat", last_rv - g, 32'd256);
    chk("tmo_err_cyc", last_err - g, 32'd256);
    repeat (60) @(negedge clk);

    // Reset in the middle of WAIT drops the transaction.
    late_dly = 10;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h13579;
    wait_gnt(g, ok);
    d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_state", 32'(dut.r_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 32'(dut.r_state), 32'd0);
    run_vec(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
